alu_cmd_ctrl: RTL and testbench
===============================

# alu_cmd_ctrl

Command-side controller that drives the 8-bit ALU and returns its results as a byte stream. Accepts one operation (operands + function code) per valid/ready handshake, pulses the ALU enable for exactly one cycle, captures the registered 16-bit result and serialises it LSB-byte-first onto a valid/ready byte interface toward the TX FIFO. Sits in the system-controller domain between the command decoder and the ALU/UART-TX path. It also guards divide-by-zero and a missing ALU result.

## Interface
- OPRND_WIDTH, 8, operand width (byte stream width equals OPRND_WIDTH)
- CTRL_WIDTH, 4, ALU function code width
- OUT_WIDTH, 2*OPRND_WIDTH, ALU result width, serialised as two bytes
- TIMEOUT, 8, max cycles spent in WAIT for ALU_VALID before abort (1..255)

Ports:
- CLK  in  1  system clock, all logic on rising edge
- RST  in  1  reset, asynchronous, active-low
- CMD_VALID  in  1  command present
- CMD_READY  out  1  controller can accept a command
- CMD_A  in  OPRND_WIDTH  operand A
- CMD_B  in  OPRND_WIDTH  operand B
- CMD_FUN  in  CTRL_WIDTH  ALU function code
- ALU_EN  out  1  ALU enable, one-cycle pulse per command
- ALU_A  out  OPRND_WIDTH  latched operand A to ALU
- ALU_B  out  OPRND_WIDTH  latched operand B to ALU
- ALU_FUN  out  CTRL_WIDTH  latched function to ALU
- ALU_OUT  in  OUT_WIDTH  ALU registered result
- ALU_VALID  in  1  ALU result valid (sticky at the ALU; qualified only in WAIT)
- TX_DATA  out  OPRND_WIDTH  result byte
- TX_VALID  out  1  TX_DATA valid
- TX_READY  in  1  downstream accepts byte
- DIV0_ERR  out  1  one-cycle pulse: divide-by-zero command seen
- TO_ERR  out  1  one-cycle pulse: ALU result timeout

## Operation
- States: IDLE, EXEC, WAIT, SEND_LO, SEND_HI.
- CMD_READY = (state == IDLE), combinational from state.
- IDLE: on CMD_VALID & CMD_READY, latch CMD_A/B/FUN into ALU_A/B/FUN. If CMD_FUN == 4'b0011 and CMD_B == 0: result register <- all ones (16'hFFFF), DIV0_ERR pulses next cycle, go SEND_LO (no EXEC, ALU_EN never asserted). Otherwise go EXEC.
- EXEC: ALU_EN = 1 for this single cycle; go WAIT; clear timeout counter.
- WAIT: if ALU_VALID, capture ALU_OUT into result register, go SEND_LO. Else increment counter; when counter reaches TIMEOUT, pulse TO_ERR, go IDLE, send nothing.
- SEND_LO: TX_VALID = 1, TX_DATA = result[7:0]; on TX_READY go SEND_HI.
- SEND_HI: TX_VALID = 1, TX_DATA = result[15:8]; on TX_READY go IDLE.
- ALU_A/B/FUN hold their value until the next accepted command; never change while ALU_EN high.
- TX_DATA stable while TX_VALID & !TX_READY; TX_VALID never drops without a transfer (except reset).
- Result captured as-is; no truncation or sign handling (ALU unsigned, e.g. subtraction underflow wraps to 16 bits as delivered by ALU).

## Timing
- Reset (RST low, async): state IDLE, CMD_READY 1, ALU_EN 0, ALU_A/B/FUN 0, TX_VALID 0, TX_DATA 0, DIV0_ERR 0, TO_ERR 0, counter 0, result 0.
- Reset mid-operation: any state returns to IDLE at once; partial byte pairs are dropped, TX_VALID falls asynchronously.
- Normal command accepted at edge k: ALU_EN high cycle k..k+1; ALU registers at edge k+1; WAIT samples ALU_VALID, capture at edge k+2; TX_VALID high from k+2; with TX_READY tied high, low byte transfers at edge k+3, high at k+4; CMD_READY high again after k+4; next accept earliest at edge k+5.
- Div-by-zero accepted at edge k: DIV0_ERR high cycle k..k+1; SEND_LO from k; bytes at edges k+1, k+2 with TX_READY high.
- Timeout: TO_ERR asserted at the edge the counter hits TIMEOUT, i.e. TIMEOUT+1 edges after entering WAIT; CMD_READY high the same cycle.
- CMD_VALID while not IDLE is ignored (no latching); upstream must hold it.

## Test plan
- Add: A=0x25, B=0x13, FUN=0000, TX_READY=1 -> ALU_EN one cycle, bytes 0x38 then 0x00, CMD_READY back after 4 edges.
- Multiply: A=0xFF, B=0xFF, FUN=0010 -> bytes 0x01 then 0xFE.
- Divide by zero: A=0x10, B=0x00, FUN=0011 -> DIV0_ERR one-cycle pulse, ALU_EN never high, bytes 0xFF, 0xFF.
- Backpressure: TX_READY low 3 cycles in SEND_LO and 2 in SEND_HI -> TX_DATA held (0x01 / 0xFE), TX_VALID stays 1, CMD_READY 0 throughout.
- Back-to-back: CMD_VALID held high with two commands (0x02+0x03, 0x09-0x04) -> accepts 5 edges apart, stream 0x05,0x00,0x05,0x00.
- Faults: ALU_VALID tied 0 with TIMEOUT=8 -> TO_ERR pulse, no TX_VALID, CMD_READY 1 afterwards; RST low during SEND_HI -> TX_VALID 0 immediately, all outputs at reset values, next command processed normally.

Source files
------------

// File: rtl/alu_cmd_ctrl.sv
// ALU command controller: accepts one operation per handshake, pulses the ALU,
// and streams the 16-bit result LSB byte first. Traps divide-by-zero and ALU timeouts.
module alu_cmd_ctrl #(
    parameter int OPRND_WIDTH = 8,
    parameter int CTRL_WIDTH  = 4,
    parameter int OUT_WIDTH   = 2*OPRND_WIDTH,
    parameter int TIMEOUT     = 8
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   CMD_VALID,
    output logic                   CMD_READY,
    input  logic [OPRND_WIDTH-1:0] CMD_A,
    input  logic [OPRND_WIDTH-1:0] CMD_B,
    input  logic [CTRL_WIDTH-1:0]  CMD_FUN,
    output logic                   ALU_EN,
    output logic [OPRND_WIDTH-1:0] ALU_A,
    output logic [OPRND_WIDTH-1:0] ALU_B,
    output logic [CTRL_WIDTH-1:0]  ALU_FUN,
    input  logic [OUT_WIDTH-1:0]   ALU_OUT,
    input  logic                   ALU_VALID,
    output logic [OPRND_WIDTH-1:0] TX_DATA,
    output logic                   TX_VALID,
    input  logic                   TX_READY,
    output logic                   DIV0_ERR,
    output logic                   TO_ERR
);

    localparam logic [CTRL_WIDTH-1:0] FUN_DIV = CTRL_WIDTH'(3);
    localparam int                    CNT_W   = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        EXEC,
        WAIT,
        SEND_LO,
        SEND_HI
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [OPRND_WIDTH-1:0] r_alu_a;
    logic [OPRND_WIDTH-1:0] r_alu_b;
    logic [CTRL_WIDTH-1:0]  r_alu_fun;
    logic [OUT_WIDTH-1:0]   r_result;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_div0_err;
    logic                   r_to_err;
    logic                   w_accept;
    logic                   w_div0;
    logic                   w_timeout;

    assign w_accept  = CMD_VALID && (r_state == IDLE);
    assign w_div0    = (CMD_FUN == FUN_DIV) && (CMD_B == '0);
    assign w_timeout = (r_state == WAIT) && !ALU_VALID && (r_cnt == CNT_W'(TIMEOUT));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next = w_div0 ? SEND_LO : EXEC;
                end
            end
            EXEC: begin
                w_next = WAIT;
            end
            WAIT: begin
                if (ALU_VALID) begin
                    w_next = SEND_LO;
                end else if (w_timeout) begin
                    w_next = IDLE;
                end
            end
            SEND_LO: begin
                if (TX_READY) begin
                    w_next = SEND_HI;
                end
            end
            SEND_HI: begin
                if (TX_READY) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_comb begin
        CMD_READY = 1'b0;
        ALU_EN    = 1'b0;
        TX_VALID  = 1'b0;
        TX_DATA   = '0;
        case (r_state)
            IDLE: begin
                CMD_READY = 1'b1;
            end
            EXEC: begin
                ALU_EN = 1'b1;
            end
            SEND_LO: begin
                TX_VALID = 1'b1;
                TX_DATA  = r_result[OPRND_WIDTH-1:0];
            end
            SEND_HI: begin
                TX_VALID = 1'b1;
                TX_DATA  = r_result[OUT_WIDTH-1:OPRND_WIDTH];
            end
            default: begin
                CMD_READY = 1'b0;
            end
        endcase
    end

    // Divide-by-zero never reaches the ALU: the all-ones result is loaded directly.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_fun  <= '0;
            r_result   <= '0;
            r_cnt      <= '0;
            r_div0_err <= 1'b0;
            r_to_err   <= 1'b0;
        end else begin
            r_div0_err <= 1'b0;
            r_to_err   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_alu_a   <= CMD_A;
                        r_alu_b   <= CMD_B;
                        r_alu_fun <= CMD_FUN;
                        if (w_div0) begin
                            r_result   <= '1;
                            r_div0_err <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    r_cnt <= '0;
                end
                WAIT: begin
                    if (ALU_VALID) begin
                        r_result <= ALU_OUT;
                    end else if (w_timeout) begin
                        r_to_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    assign ALU_A    = r_alu_a;
    assign ALU_B    = r_alu_b;
    assign ALU_FUN  = r_alu_fun;
    assign DIV0_ERR = r_div0_err;
    assign TO_ERR   = r_to_err;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Scoreboard bench for alu_cmd_ctrl: directed scenarios plus randomized commands,
// with a behavioural ALU and an independent byte-stream monitor.
module tb_alu_cmd_ctrl;

    localparam int OW  = 8;
    localparam int CW  = 4;
    localparam int RW  = 16;
    localparam int TMO = 8;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          CMD_VALID = 1'b0;
    logic          CMD_READY;
    logic [OW-1:0] CMD_A = '0;
    logic [OW-1:0] CMD_B = '0;
    logic [CW-1:0] CMD_FUN = '0;
    logic          ALU_EN;
    logic [OW-1:0] ALU_A;
    logic [OW-1:0] ALU_B;
    logic [CW-1:0] ALU_FUN;
    logic [RW-1:0] ALU_OUT;
    logic          ALU_VALID;
    logic [OW-1:0] TX_DATA;
    logic          TX_VALID;
    logic          TX_READY = 1'b1;
    logic          DIV0_ERR;
    logic          TO_ERR;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    logic [7:0] expQ[$];
    int expAluEn = 0, expDiv0 = 0, expTo = 0;
    int seenAluEn = 0, seenDiv0 = 0, seenTo = 0;

    bit rndReady = 0;
    bit aluDead  = 0;
    int aluLat   = 0;

    alu_cmd_ctrl #(
        .OPRND_WIDTH(OW), .CTRL_WIDTH(CW), .OUT_WIDTH(RW), .TIMEOUT(TMO)
    ) dut (
        .CLK(CLK), .RST(RST),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_A(CMD_A), .CMD_B(CMD_B), .CMD_FUN(CMD_FUN),
        .ALU_EN(ALU_EN), .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN),
        .ALU_OUT(ALU_OUT), .ALU_VALID(ALU_VALID),
        .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
        .DIV0_ERR(DIV0_ERR), .TO_ERR(TO_ERR)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [15:0] refAlu(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
        case (f)
            4'd0:    return 16'(a) + 16'(b);
            4'd1:    return 16'(a) - 16'(b);
            4'd2:    return 16'(a) * 16'(b);
            4'd3:    return (b == 8'd0) ? 16'hFFFF : 16'(a / b);
            4'd4:    return {8'h00, a & b};
            4'd5:    return {8'h00, a | b};
            4'd6:    return {8'h00, a ^ b};
            default: return {a, b};
        endcase
    endfunction

    // Behavioural ALU: result appears aluLat cycles after the enable edge, valid is sticky.
    logic [15:0] aluPending;
    logic        aluValidR;
    int          aluCnt;
    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ALU_OUT    <= '0;
            aluValidR  <= 1'b0;
            aluCnt     <= 0;
            aluPending <= '0;
        end else if (ALU_EN) begin
            aluPending <= refAlu(ALU_A, ALU_B, ALU_FUN);
            if (aluLat == 0) begin
                ALU_OUT   <= refAlu(ALU_A, ALU_B, ALU_FUN);
                aluValidR <= 1'b1;
            end else begin
                aluValidR <= 1'b0;
                aluCnt    <= aluLat;
            end
        end else if (aluCnt != 0) begin
            aluCnt <= aluCnt - 1;
            if (aluCnt == 1) begin
                ALU_OUT   <= aluPending;
                aluValidR <= 1'b1;
            end
        end
    end
    assign ALU_VALID = aluValidR && !aluDead;

    always @(posedge CLK) begin
        #1;
        if (rndReady) TX_READY = ($urandom_range(0, 3) != 0);
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f,
                                 input bit hold, output int acceptEdge);
        bit ok = 0;
        logic [15:0] exp;
        acceptEdge = -1;
        CMD_A = a; CMD_B = b; CMD_FUN = f; CMD_VALID = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge CLK);
            if (CMD_READY) begin
                ok = 1;
                acceptEdge = cyc + 1;
            end
        end
        checkOutput("cmd_accepted", ok, 1);
        if (!ok) begin
            CMD_VALID = 1'b0;
            return;
        end
        if (f == 4'd3 && b == 8'd0) begin
            expDiv0++;
            exp = 16'hFFFF;
            expQ.push_back(exp[7:0]);
            expQ.push_back(exp[15:8]);
        end else begin
            expAluEn++;
            if (aluDead) begin
                expTo++;
            end else begin
                exp = refAlu(a, b, f);
                expQ.push_back(exp[7:0]);
                expQ.push_back(exp[15:8]);
            end
        end
        @(posedge CLK);
        #1;
        if (!hold) CMD_VALID = 1'b0;
    endtask

    task automatic waitDrain(input string name);
        bit done = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge CLK);
            if (expQ.size() == 0 && CMD_READY && !TX_VALID) done = 1;
        end
        checkOutput(name, done, 1);
        @(posedge CLK);
        #1;
    endtask

    // Monitor: pops the scoreboard on every byte transfer and watches handshake rules.
    bit         prevStall = 0;
    bit         prevEn    = 0;
    logic [7:0] prevData  = '0;
    always @(negedge CLK) begin
        logic [7:0] e;
        if (!RST) begin
            prevStall = 0;
            prevEn    = 0;
        end else begin
            if (prevStall) begin
                checkOutput("tx_valid_held", TX_VALID, 1);
                checkOutput("tx_data_held", TX_DATA, prevData);
            end
            if (TX_VALID && TX_READY) begin
                checkOutput("byte_expected", expQ.size() != 0, 1);
                if (expQ.size() != 0) begin
                    e = expQ.pop_front();
                    checkOutput("tx_byte", TX_DATA, e);
                end
            end
            if (ALU_EN) begin
                seenAluEn++;
                checkOutput("alu_en_single_cycle", prevEn, 0);
            end
            if (DIV0_ERR) seenDiv0++;
            if (TO_ERR)   seenTo++;
            prevStall = TX_VALID && !TX_READY;
            prevData  = TX_DATA;
            prevEn    = ALU_EN;
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int acc, acc2, t0;
        bit seen;
        logic [3:0] f;
        logic [7:0] a, b;

        @(negedge CLK);
        checkOutput("rst_cmd_ready", CMD_READY, 1);
        checkOutput("rst_alu_en", ALU_EN, 0);
        checkOutput("rst_alu_a", ALU_A, 0);
        checkOutput("rst_alu_b", ALU_B, 0);
        checkOutput("rst_alu_fun", ALU_FUN, 0);
        checkOutput("rst_tx_valid", TX_VALID, 0);
        checkOutput("rst_tx_data", TX_DATA, 0);
        checkOutput("rst_div0", DIV0_ERR, 0);
        checkOutput("rst_to", TO_ERR, 0);
        @(posedge CLK); #1 RST = 1'b1;
        @(posedge CLK); #1;

        $display("[TB] add with cycle-level timing");
        applyStimulus(8'h25, 8'h13, 4'd0, 0, acc);
        @(negedge CLK);
        checkOutput("add_alu_en_k", ALU_EN, 1);
        checkOutput("add_busy", CMD_READY, 0);
        checkOutput("add_alu_a", ALU_A, 8'h25);
        checkOutput("add_alu_b", ALU_B, 8'h13);
        @(negedge CLK);
        checkOutput("add_alu_en_k1", ALU_EN, 0);
        checkOutput("add_no_tx_k1", TX_VALID, 0);
        @(negedge CLK);
        checkOutput("add_tx_valid_k2", TX_VALID, 1);
        checkOutput("add_lo_byte", TX_DATA, 8'h38);
        @(negedge CLK);
        checkOutput("add_hi_byte", TX_DATA, 8'h00);
        @(negedge CLK);
        checkOutput("add_ready_k4", CMD_READY, 1);
        @(posedge CLK); #1;

        $display("[TB] multiply");
        applyStimulus(8'hFF, 8'hFF, 4'd2, 0, acc);
        waitDrain("mul_drain");

        $display("[TB] divide by zero");
        applyStimulus(8'h10, 8'h00, 4'd3, 0, acc);
        @(negedge CLK);
        checkOutput("div0_pulse", DIV0_ERR, 1);
        checkOutput("div0_tx_valid", TX_VALID, 1);
        checkOutput("div0_lo", TX_DATA, 8'hFF);
        checkOutput("div0_no_alu_en", ALU_EN, 0);
        @(negedge CLK);
        checkOutput("div0_pulse_end", DIV0_ERR, 0);
        checkOutput("div0_no_alu_en2", ALU_EN, 0);
        waitDrain("div0_drain");

        $display("[TB] backpressure");
        TX_READY = 1'b0;
        applyStimulus(8'hFF, 8'hFF, 4'd2, 0, acc);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge CLK);
            if (TX_VALID) seen = 1;
        end
        checkOutput("bp_tx_valid_seen", seen, 1);
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            checkOutput("bp_lo_data", TX_DATA, 8'h01);
            checkOutput("bp_lo_busy", CMD_READY, 0);
        end
        @(posedge CLK); #1 TX_READY = 1'b1;
        @(posedge CLK); #1 TX_READY = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            checkOutput("bp_hi_valid", TX_VALID, 1);
            checkOutput("bp_hi_data", TX_DATA, 8'hFE);
            checkOutput("bp_hi_busy", CMD_READY, 0);
        end
        @(posedge CLK); #1 TX_READY = 1'b1;
        waitDrain("bp_drain");

        $display("[TB] back-to-back");
        applyStimulus(8'h02, 8'h03, 4'd0, 1, acc);
        applyStimulus(8'h09, 8'h04, 4'd1, 0, acc2);
        checkOutput("b2b_spacing", acc2 - acc, 5);
        waitDrain("b2b_drain");

        $display("[TB] ALU timeout");
        aluDead = 1;
        applyStimulus(8'h07, 8'h07, 4'd0, 0, acc);
        seen = 0;
        t0 = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge CLK);
            if (TO_ERR) begin
                seen = 1;
                t0 = cyc;
                checkOutput("to_ready_same_cycle", CMD_READY, 1);
                checkOutput("to_no_tx", TX_VALID, 0);
            end
        end
        checkOutput("to_seen", seen, 1);
        checkOutput("to_latency", t0 - acc, TMO + 2);
        @(negedge CLK);
        checkOutput("to_pulse_end", TO_ERR, 0);
        @(posedge CLK); #1 aluDead = 0;

        $display("[TB] reset during SEND_HI");
        TX_READY = 1'b0;
        applyStimulus(8'h80, 8'h04, 4'd2, 0, acc);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge CLK);
            if (TX_VALID) seen = 1;
        end
        checkOutput("rstmid_tx_seen", seen, 1);
        @(posedge CLK); #1 TX_READY = 1'b1;
        @(posedge CLK); #1 TX_READY = 1'b0;
        @(negedge CLK);
        checkOutput("rstmid_hi_data", TX_DATA, 8'h02);
        #2 RST = 1'b0;
        expQ.delete();
        #1;
        checkOutput("rstmid_tx_valid", TX_VALID, 0);
        checkOutput("rstmid_tx_data", TX_DATA, 0);
        checkOutput("rstmid_cmd_ready", CMD_READY, 1);
        checkOutput("rstmid_alu_a", ALU_A, 0);
        checkOutput("rstmid_alu_en", ALU_EN, 0);
        @(posedge CLK); @(posedge CLK); #1;
        RST = 1'b1;
        TX_READY = 1'b1;
        applyStimulus(8'h25, 8'h13, 4'd0, 0, acc);
        waitDrain("post_reset_drain");

        $display("[TB] randomized commands");
        rndReady = 1;
        for (int n = 0; n < 40; n++) begin
            f = 4'($urandom_range(0, 7));
            a = 8'($urandom);
            b = 8'($urandom);
            if (f == 4'd3 && $urandom_range(0, 3) == 0) b = 8'h00;
            aluLat = $urandom_range(0, 3);
            repeat ($urandom_range(0, 2)) begin
                @(posedge CLK); #1;
            end
            applyStimulus(a, b, f, 0, acc);
        end
        @(posedge CLK); #1;
        rndReady = 0;
        TX_READY = 1'b1;
        waitDrain("rand_drain");

        checkOutput("alu_en_count", seenAluEn, expAluEn);
        checkOutput("div0_count", seenDiv0, expDiv0);
        checkOutput("to_count", seenTo, expTo);
        checkOutput("queue_left", expQ.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
